// File: rtl/ram_port_arbiter.sv
// Shares the single RAMHelper port between instruction fetch and the LSU.
// LSU has priority; fetch is forced through after STARVE_LIMIT contested losses.
module ram_port_arbiter #(
    parameter logic [63:0] RAM_BASE     = 64'h0000_0000_8000_0000,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_valid,
    input  logic [63:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [63:0] if_resp_data,

    input  logic        lsu_req_valid,
    input  logic        lsu_req_we,
    input  logic [63:0] lsu_req_addr,
    input  logic [63:0] lsu_req_wdata,
    input  logic [63:0] lsu_req_wmask,
    output logic        lsu_req_ready,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_resp_data,

    output logic        ram_ren,
    output logic [63:0] ram_raddr,
    input  logic [63:0] ram_rdata,
    output logic        ram_wen,
    output logic [63:0] ram_waddr,
    output logic [63:0] ram_wdata,
    output logic [63:0] ram_wmask
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LSU_RD,
        OWN_LSU_WR
    } owner_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    owner_t     owner, ownerNext;
    logic [3:0] starveCnt, starveCntNext;
    logic       contested, grantIf, grantLsu;
    logic [63:0] ifIndex, lsuIndex;

    assign ifIndex  = (if_req_addr  - RAM_BASE) >> 3;
    assign lsuIndex = (lsu_req_addr - RAM_BASE) >> 3;

    // Grants are masked during reset so nothing is accepted while rst is high.
    always_comb begin
        contested = if_req_valid && lsu_req_valid;
        grantLsu  = !rst && lsu_req_valid && !(contested && starveCnt == STARVE_MAX);
        grantIf   = !rst && if_req_valid && !grantLsu;
    end

    always_comb begin
        starveCntNext = '0;
        if (contested && grantLsu && starveCnt != STARVE_MAX)
            starveCntNext = starveCnt + 4'd1;
        else if (contested && grantLsu)
            starveCntNext = starveCnt;

        ownerNext = OWN_NONE;
        if (grantIf)
            ownerNext = OWN_IF;
        else if (grantLsu)
            ownerNext = lsu_req_we ? OWN_LSU_WR : OWN_LSU_RD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWN_NONE;
            starveCnt <= '0;
        end else begin
            owner     <= ownerNext;
            starveCnt <= starveCntNext;
        end
    end

    always_comb begin
        if_req_ready  = grantIf;
        lsu_req_ready = grantLsu;

        ram_ren   = 1'b0;
        ram_raddr = '0;
        ram_wen   = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_wmask = '0;
        if (grantIf) begin
            ram_ren   = 1'b1;
            ram_raddr = ifIndex;
        end else if (grantLsu && !lsu_req_we) begin
            ram_ren   = 1'b1;
            ram_raddr = lsuIndex;
        end else if (grantLsu) begin
            ram_wen   = 1'b1;
            ram_waddr = lsuIndex;
            ram_wdata = lsu_req_wdata;
            ram_wmask = lsu_req_wmask;
        end

        if_resp_valid  = (owner == OWN_IF);
        if_resp_data   = (owner == OWN_IF) ? ram_rdata : '0;
        lsu_resp_valid = (owner == OWN_LSU_RD) || (owner == OWN_LSU_WR);
        lsu_resp_data  = (owner == OWN_LSU_RD) ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: RAM read data is driven by hand,
// each check is an immediate assertion with hand-computed expectations.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [63:0] if_resp_data;
    logic        lsu_req_valid;
    logic        lsu_req_we;
    logic [63:0] lsu_req_addr;
    logic [63:0] lsu_req_wdata;
    logic [63:0] lsu_req_wmask;
    logic        lsu_req_ready;
    logic        lsu_resp_valid;
    logic [63:0] lsu_resp_data;
    logic        ram_ren;
    logic [63:0] ram_raddr;
    logic [63:0] ram_rdata;
    logic        ram_wen;
    logic [63:0] ram_waddr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_wmask;

    int nChecks = 0;
    int nFails  = 0;

    ram_port_arbiter #(
        .RAM_BASE(64'h0000_0000_8000_0000),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req_valid(if_req_valid),
        .if_req_addr(if_req_addr),
        .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid),
        .if_resp_data(if_resp_data),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_we(lsu_req_we),
        .lsu_req_addr(lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata),
        .lsu_req_wmask(lsu_req_wmask),
        .lsu_req_ready(lsu_req_ready),
        .lsu_resp_valid(lsu_resp_valid),
        .lsu_resp_data(lsu_resp_data),
        .ram_ren(ram_ren),
        .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata),
        .ram_wen(ram_wen),
        .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata),
        .ram_wmask(ram_wmask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One arbitration cycle with LSU reads: checks grants now and responses from the previous grant.
    task automatic arbCycle(input string tag, input logic ifv, input logic lsuv,
                            input logic expIf, input logic expLsu,
                            input logic prevIf, input logic prevLsu);
        if_req_valid  = ifv;
        if_req_addr   = 64'h8000_0000;
        lsu_req_valid = lsuv;
        lsu_req_we    = 1'b0;
        lsu_req_addr  = 64'h8000_0020;
        #1;
        chk({tag, ".if_ready"}, 64'(if_req_ready), 64'(expIf));
        chk({tag, ".lsu_ready"}, 64'(lsu_req_ready), 64'(expLsu));
        chk({tag, ".if_resp_valid"}, 64'(if_resp_valid), 64'(prevIf));
        chk({tag, ".lsu_resp_valid"}, 64'(lsu_resp_valid), 64'(prevLsu));
        nextCycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr = 64'h8000_0010;
        lsu_req_valid = 1'b0;
        lsu_req_we = 1'b0;
        lsu_req_addr = '0;
        lsu_req_wdata = '0;
        lsu_req_wmask = '0;
        ram_rdata = 64'h5555_5555_5555_5555;
        #2;
        chk("rst.if_ready", 64'(if_req_ready), 64'd0);
        chk("rst.lsu_ready", 64'(lsu_req_ready), 64'd0);
        chk("rst.if_resp_valid", 64'(if_resp_valid), 64'd0);
        chk("rst.lsu_resp_valid", 64'(lsu_resp_valid), 64'd0);
        chk("rst.ram_ren", 64'(ram_ren), 64'd0);
        chk("rst.ram_wen", 64'(ram_wen), 64'd0);
        chk("rst.if_resp_data", if_resp_data, 64'd0);
        if_req_valid = 1'b0;
        nextCycle();
        nextCycle();
        rst = 1'b0;

        // IF read of 0x8000_0010
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0010;
        #1;
        chk("ifrd.ready", 64'(if_req_ready), 64'd1);
        chk("ifrd.ren", 64'(ram_ren), 64'd1);
        chk("ifrd.raddr", ram_raddr, 64'd2);
        chk("ifrd.wen", 64'(ram_wen), 64'd0);
        chk("ifrd.lsu_ready", 64'(lsu_req_ready), 64'd0);
        nextCycle();
        if_req_valid = 1'b0;
        ram_rdata = 64'h1122_3344_5566_7788;
        #1;
        chk("ifrd.resp_valid", 64'(if_resp_valid), 64'd1);
        chk("ifrd.resp_data", if_resp_data, 64'h1122_3344_5566_7788);
        chk("ifrd.lsu_resp_valid", 64'(lsu_resp_valid), 64'd0);
        chk("idle.ren", 64'(ram_ren), 64'd0);
        chk("idle.raddr", ram_raddr, 64'd0);
        nextCycle();

        // LSU write
        lsu_req_valid = 1'b1;
        lsu_req_we    = 1'b1;
        lsu_req_addr  = 64'h8000_0008;
        lsu_req_wdata = 64'hDEAD_BEEF;
        lsu_req_wmask = 64'hFFFF_FFFF;
        #1;
        chk("wr.ready", 64'(lsu_req_ready), 64'd1);
        chk("wr.wen", 64'(ram_wen), 64'd1);
        chk("wr.waddr", ram_waddr, 64'd1);
        chk("wr.wdata", ram_wdata, 64'hDEAD_BEEF);
        chk("wr.wmask", ram_wmask, 64'hFFFF_FFFF);
        chk("wr.ren", 64'(ram_ren), 64'd0);
        nextCycle();
        lsu_req_valid = 1'b0;
        lsu_req_we    = 1'b0;
        ram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("wr.resp_valid", 64'(lsu_resp_valid), 64'd1);
        chk("wr.resp_data", lsu_resp_data, 64'd0);
        chk("wr.if_resp_valid", 64'(if_resp_valid), 64'd0);
        chk("idle.wen", 64'(ram_wen), 64'd0);
        nextCycle();

        // Contention, limit 4; a non-contested cycle clears the count
        arbCycle("c1",  1, 1, 0, 1, 0, 0);
        arbCycle("c2",  1, 1, 0, 1, 0, 1);
        arbCycle("c3",  1, 1, 0, 1, 0, 1);
        arbCycle("c4",  1, 1, 0, 1, 0, 1);
        arbCycle("c5",  1, 1, 1, 0, 0, 1);
        arbCycle("c6",  1, 1, 0, 1, 1, 0);
        arbCycle("c7",  1, 1, 0, 1, 0, 1);
        arbCycle("c8",  1, 1, 0, 1, 0, 1);
        arbCycle("c9",  0, 1, 0, 1, 0, 1);
        arbCycle("c10", 1, 1, 0, 1, 0, 1);
        arbCycle("c11", 1, 1, 0, 1, 0, 1);
        arbCycle("c12", 1, 1, 0, 1, 0, 1);
        arbCycle("c13", 1, 1, 0, 1, 0, 1);
        arbCycle("c14", 1, 1, 1, 0, 0, 1);
        arbCycle("c15", 0, 0, 0, 0, 1, 0);
        arbCycle("c16", 1, 0, 1, 0, 0, 0);
        if_req_valid = 1'b0;
        nextCycle();

        // Back-to-back reads: IF then LSU
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0000;
        #1;
        chk("b2b.if_ready", 64'(if_req_ready), 64'd1);
        chk("b2b.raddr0", ram_raddr, 64'd0);
        nextCycle();
        if_req_valid  = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_req_we    = 1'b0;
        lsu_req_addr  = 64'h8000_0018;
        ram_rdata = 64'hAAAA_0000_BBBB_0001;
        #1;
        chk("b2b.lsu_ready", 64'(lsu_req_ready), 64'd1);
        chk("b2b.raddr3", ram_raddr, 64'd3);
        chk("b2b.if_resp_valid", 64'(if_resp_valid), 64'd1);
        chk("b2b.if_resp_data", if_resp_data, 64'hAAAA_0000_BBBB_0001);
        chk("b2b.lsu_resp_valid0", 64'(lsu_resp_valid), 64'd0);
        nextCycle();
        lsu_req_valid = 1'b0;
        ram_rdata = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("b2b.lsu_resp_valid", 64'(lsu_resp_valid), 64'd1);
        chk("b2b.lsu_resp_data", lsu_resp_data, 64'h0123_4567_89AB_CDEF);
        chk("b2b.if_resp_valid1", 64'(if_resp_valid), 64'd0);
        nextCycle();

        // Reset while an LSU read is being granted
        lsu_req_valid = 1'b1;
        lsu_req_we    = 1'b0;
        lsu_req_addr  = 64'h8000_0008;
        #1;
        chk("rmid.lsu_ready", 64'(lsu_req_ready), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rmid.ready_in_rst", 64'(lsu_req_ready), 64'd0);
        nextCycle();
        chk("rmid.lsu_resp_valid", 64'(lsu_resp_valid), 64'd0);
        rst = 1'b0;
        lsu_req_valid = 1'b0;
        #1;
        chk("rmid.lsu_resp_valid2", 64'(lsu_resp_valid), 64'd0);
        nextCycle();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0010;
        #1;
        chk("rmid.if_ready", 64'(if_req_ready), 64'd1);
        chk("rmid.raddr", ram_raddr, 64'd2);
        nextCycle();
        if_req_valid = 1'b0;
        ram_rdata = 64'hCAFE_F00D_0000_1234;
        #1;
        chk("rmid.if_resp_valid", 64'(if_resp_valid), 64'd1);
        chk("rmid.if_resp_data", if_resp_data, 64'hCAFE_F00D_0000_1234);
        nextCycle();

        // Address below RAM_BASE wraps
        if_req_valid = 1'b1;
        if_req_addr  = 64'h7FFF_FFF8;
        #1;
        chk("wrap.ready", 64'(if_req_ready), 64'd1);
        chk("wrap.raddr", ram_raddr, 64'h1FFF_FFFF_FFFF_FFFF);
        nextCycle();
        if_req_valid = 1'b0;
        #1;
        chk("wrap.resp_valid", 64'(if_resp_valid), 64'd1);
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
